// File: rtl/detect_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Overlap mode is selected with the DETECT_OVERLAP_EN macro.
package detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  function automatic logic [4:0] clamp_len(
    input logic [4:0] len,
    input logic [4:0] max_len
  );
    logic [4:0] r;
    r = len;
    if (len == 5'd0) r = 5'd1;
    else if (len > max_len) r = max_len;
    return r;
  endfunction

endpackage

// File: rtl/detect_shreg.sv
// History shift register plus saturating count of bits seen.
// Clear has priority over shift.
module detect_shreg
  import detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic [4:0]         i_len,
  output logic [MAX_LEN-1:0] o_hist,
  output logic [4:0]         o_seen
);

  logic [MAX_LEN-1:0] r_hist;
  logic [4:0]         r_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (i_shift) begin
      r_hist <= {r_hist[MAX_LEN-2:0], i_bit};
      if (r_seen < i_len) r_seen <= r_seen + 5'd1;
    end
  end

  assign o_hist = r_hist;
  assign o_seen = r_seen;

endmodule

// File: rtl/detect_ctrl.sv
// Serial pattern detector: FSM, config latch, comparator, match counter.
// Define DETECT_OVERLAP_EN to keep history after a match (overlapping hits).
module detect_ctrl
  import detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [4:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               s_valid,
  input  logic               s_bit,
  output logic               s_ready,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  state_t r_state, w_next;

  logic [MAX_LEN-1:0] r_pat;
  logic [4:0]         r_len;
  logic [CNT_W-1:0]   r_tgt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_match;

  logic [MAX_LEN-1:0] w_hist;
  logic [4:0]         w_seen;
  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_start;
  logic               w_acc;
  logic               w_hit;
  logic               w_clr;
  logic               w_tgt_hit;

  assign w_start = start & ~stop;
  assign s_ready = (r_state == RUN) & ~stop;
  // A start in RUN restarts the scan and drops the offered bit.
  assign w_acc   = s_valid & s_ready & ~start;

  assign w_cand = {w_hist[MAX_LEN-2:0], s_bit};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_mask[i] = (i < int'(r_len));
  end

  assign w_hit = w_acc
    & (({1'b0, w_seen} + 6'd1) >= {1'b0, r_len})
    & (((w_cand ^ r_pat) & w_mask) == '0);

  assign w_cnt_inc = (&r_cnt) ? r_cnt
    : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_tgt_hit = w_hit & (r_tgt != '0) & (w_cnt_inc == r_tgt);

`ifdef DETECT_OVERLAP_EN
  assign w_clr = w_start;
`else
  assign w_clr = w_start | w_hit;
`endif

  detect_shreg #(
    .MAX_LEN(MAX_LEN)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clr),
    .i_shift (w_acc),
    .i_bit   (s_bit),
    .i_len   (r_len),
    .o_hist  (w_hist),
    .o_seen  (w_seen)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_next = RUN;
      RUN: begin
        if (stop)           w_next = IDLE;
        else if (start)     w_next = RUN;
        else if (w_tgt_hit) w_next = DONE;
      end
      DONE: begin
        if (stop)       w_next = IDLE;
        else if (start) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_start) begin
        r_pat <= cfg_pattern;
        r_len <= clamp_len(cfg_len, 5'(MAX_LEN));
        r_tgt <= cfg_target;
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_detect_ctrl.sv
// Directed bench for detect_ctrl with a match scoreboard.
// Expected values follow the DETECT_OVERLAP_EN setting of the build.
module tb_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [4:0] cfg_len = '0;
  logic [7:0] cfg_target = '0;
  logic       s_valid = 1'b0;
  logic       s_bit = 1'b0;
  logic       s_ready, match, busy, done;
  logic [7:0] match_cnt;
  logic       s_ready2, match2, busy2, done2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

`ifdef DETECT_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  always #5 clk = ~clk;

  detect_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_target(cfg_target), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready), .match(match), .match_cnt(match_cnt),
    .busy(busy), .done(done)
  );

  detect_ctrl #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_target(cfg_target[1:0]), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready2), .match(match2), .match_cnt(match_cnt2),
    .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [4:0] len,
                          input logic [7:0] tgt);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_target  = tgt;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic exp);
    logic e;
    exp_q.push_back(exp);
    s_valid = 1'b1;
    s_bit   = b;
    tick();
    s_valid = 1'b0;
    e = exp_q.pop_front();
    chk("match", match, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    tick();
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", s_ready, 0);
    reset = 1'b0;
    tick();
    chk("idle_ready", s_ready, 0);

    // overlap scenario: 010 over stream 0,1,0,1,0
    do_start(8'b010, 5'd3, 8'd0);
    chk("run_busy", busy, 1);
    chk("run_ready", s_ready, 1);
    chk("run_cnt0", match_cnt, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, OVL);
    tick();
    chk("pulse_end", match, 0);
    chk("ovl_cnt", match_cnt, OVL ? 2 : 1);

    // stop with a valid bit offered
    stop = 1'b1; s_valid = 1'b1; s_bit = 1'b0;
    #1;
    chk("stop_ready", s_ready, 0);
    tick();
    stop = 1'b0; s_valid = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_hold", match_cnt, OVL ? 2 : 1);
    chk("stop_nomatch", match, 0);

    // target reached: 11, target 2
    do_start(8'b11, 5'd2, 8'd2);
    chk("rst_cnt_start", match_cnt, 0);
    chk("restart_busy", busy, 1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, OVL);
    send_bit(1'b1, !OVL);
    chk("tgt_done", done, 1);
    chk("tgt_busy", busy, 0);
    chk("tgt_ready", s_ready, 0);
    chk("tgt_cnt", match_cnt, 2);
    send_bit(1'b1, 1'b0);
    chk("done_hold", match_cnt, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("done_stop", done, 0);

    // len 0 treated as 1, then restart in RUN drops the bit
    do_start(8'b1, 5'd0, 8'd0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("len0_cnt", match_cnt, 2);
    start = 1'b1; s_valid = 1'b1; s_bit = 1'b1;
    tick();
    start = 1'b0; s_valid = 1'b0;
    chk("rs_match", match, 0);
    chk("rs_cnt", match_cnt, 0);
    chk("rs_busy", busy, 1);
    send_bit(1'b1, 1'b1);
    chk("rs_cnt1", match_cnt, 1);

    // s_valid low holds count
    tick();
    tick();
    chk("idle_hold", match_cnt, 1);

    // cfg_len 20 clamps to 8
    do_start(8'hA5, 5'd20, 8'd0);
    for (int i = 7; i >= 0; i--)
      send_bit(a5[i], i == 0);
    chk("clamp_cnt", match_cnt, 1);

    // CNT_W=2 saturation
    do_start(8'b1, 5'd1, 8'd0);
    for (int i = 0; i < 5; i++)
      send_bit(1'b1, 1'b1);
    chk("sat_cnt2", match_cnt2, 3);
    chk("sat_cnt8", match_cnt, 5);

    // reset between match edge and its pulse
    do_start(8'b1, 5'd1, 8'd0);
    s_valid = 1'b1; s_bit = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("mid_match", match, 0);
    chk("mid_cnt", match_cnt, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_ready", s_ready, 0);
    tick();
    chk("mid_match2", match, 0);
    reset = 1'b0;
    tick();
    chk("post_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
